// File: rtl/pair_stream_arbiter.sv
// Round-robin arbiter that shares one pair detector between two frame requesters:
// serialises a guarded frame onto the detector stream and returns the per-frame pair count.
module pair_stream_arbiter #(
    parameter int W  = 16,
    parameter int LW = $clog2(W + 1)
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic [1:0]    req,
    input  logic [W-1:0]  data0,
    input  logic [LW-1:0] len0,
    input  logic [W-1:0]  data1,
    input  logic [LW-1:0] len1,
    output logic [1:0]    gnt,
    output logic          stream,
    input  logic          det_out,
    output logic          busy,
    output logic          done,
    output logic          done_id,
    output logic [LW-1:0] hits
);
    typedef enum logic [2:0] {IDLE, GUARD0, GUARD1, SEND, DRAIN, DONE} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  sh;
    logic [LW-1:0] cnt, acc, acc_nxt, len_sel, len_c;
    logic          last, cur_id, drain2, send_d1, send_d2;
    logic          take, take_id;

    // Grant only while out of reset so a held req cannot leak a gnt during reset.
    always_comb begin
        take    = 1'b0;
        take_id = 1'b0;
        if (state == IDLE && sys_rst_n) begin
            case (req)
                2'b01:   begin take = 1'b1; take_id = 1'b0;  end
                2'b10:   begin take = 1'b1; take_id = 1'b1;  end
                2'b11:   begin take = 1'b1; take_id = ~last; end
                default: ;
            endcase
        end
        len_sel = take_id ? len1 : len0;
        len_c   = (len_sel > LW'(W)) ? LW'(W) : len_sel;
        acc_nxt = take ? '0 : acc + LW'(send_d2 & det_out);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = (len_c == '0) ? DONE : GUARD0;
            GUARD0:  state_nxt = GUARD1;
            GUARD1:  state_nxt = SEND;
            SEND:    if (cnt <= LW'(1)) state_nxt = DRAIN;
            DRAIN:   if (drain2) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt     = take ? (take_id ? 2'b10 : 2'b01) : 2'b00;
        busy    = take || (state != IDLE);
        done    = (state == DONE);
        done_id = cur_id;
    end

    // Stream is registered one cycle ahead of the state that owns each bit;
    // the count window trails SEND by the detector's two-cycle latency.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sh      <= '0;
            cnt     <= '0;
            acc     <= '0;
            hits    <= '0;
            last    <= 1'b1;
            cur_id  <= 1'b0;
            drain2  <= 1'b0;
            send_d1 <= 1'b0;
            send_d2 <= 1'b0;
            stream  <= 1'b0;
        end else begin
            send_d1 <= (state == SEND);
            send_d2 <= send_d1;
            drain2  <= (state == DRAIN) && !drain2;
            acc     <= acc_nxt;
            stream  <= 1'b0;
            case (state)
                IDLE: if (take) begin
                    sh     <= take_id ? data1 : data0;
                    cnt    <= len_c;
                    last   <= take_id;
                    cur_id <= take_id;
                    if (len_c != '0) stream <= take_id ? data1[0] : data0[0];
                end
                GUARD0: stream <= ~sh[0];
                GUARD1: begin
                    stream <= sh[0];
                    sh     <= sh >> 1;
                end
                SEND: begin
                    if (cnt > LW'(1)) stream <= sh[0];
                    sh  <= sh >> 1;
                    cnt <= cnt - LW'(1);
                end
                default: ;
            endcase
            if (state_nxt == DONE && state != DONE) hits <= acc_nxt;
        end
    end
endmodule

// File: tb/tb_pair_stream_arbiter.sv
// Scoreboard bench for pair_stream_arbiter with a behavioural pair detector
// (non-overlapping equal-bit pairs, pulse two cycles after the pair's second bit).
module tb_pair_stream_arbiter;
    localparam int W  = 16;
    localparam int LW = 5;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic [1:0]    req = 2'b00;
    logic [W-1:0]  data0 = '0, data1 = '0;
    logic [LW-1:0] len0 = '0, len1 = '0;
    logic [1:0]    gnt;
    logic          stream, busy, done, done_id;
    logic [LW-1:0] hits;
    logic          det_out;

    pair_stream_arbiter #(.W(W), .LW(LW)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .req(req),
        .data0(data0), .len0(len0), .data1(data1), .len1(len1),
        .gnt(gnt), .stream(stream), .det_out(det_out), .busy(busy),
        .done(done), .done_id(done_id), .hits(hits)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Detector model with its own reset so its state survives arbiter resets.
    logic det_rst_n = 1'b0;
    logic have, val, pend;
    always @(posedge sys_clk or negedge det_rst_n) begin
        if (!det_rst_n) begin
            have <= 1'b0; val <= 1'b0; pend <= 1'b0; det_out <= 1'b0;
        end else begin
            pend <= 1'b0;
            if (have && val == stream) begin
                pend <= 1'b1;
                have <= 1'b0;
            end else begin
                have <= 1'b1;
                val  <= stream;
            end
            det_out <= pend;
        end
    end

    int n_cmp = 0, n_bad = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d want %0d", name, cyc, act, exp);
        end
    endfunction

    typedef struct {int id; int hits; int c;} exp_t;
    exp_t exp_q[$];

    typedef struct {int c; int g;} glog_t;
    glog_t glog[$];

    always @(negedge sys_clk) begin
        if (sys_rst_n && done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done @cyc %0d: got done_id %0d hits %0d want no done", cyc, done_id, hits);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_id", int'(done_id), e.id);
                chk("hits", int'(hits), e.hits);
                chk("done_cycle", cyc, e.c);
            end
        end
        if (gnt != 2'b00) begin
            chk("gnt_onehot", $countones(gnt), 1);
            glog.push_back('{cyc, int'(gnt)});
        end
    end

    task automatic rf(input int id, input logic [W-1:0] d, input int len, input int eh);
        int  g, lc, last_busy;
        bit  got;
        logic exp_s;
        lc = (len > W) ? W : len;
        @(posedge sys_clk); #1;
        if (id == 0) begin data0 = d; len0 = LW'(len); end
        else         begin data1 = d; len1 = LW'(len); end
        req[id] = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge sys_clk);
            if (gnt[id]) got = 1'b1;
        end
        if (!got) begin
            chk("gnt_timeout", 0, 1);
            req[id] = 1'b0;
            return;
        end
        g = cyc;
        chk("busy_at_grant", int'(busy), 1);
        exp_q.push_back('{id, eh, (lc == 0) ? g + 1 : g + lc + 5});
        @(posedge sys_clk); #1;
        req[id] = 1'b0;
        if (id == 0) data0 = ~d; else data1 = ~d;
        last_busy = (lc == 0) ? 1 : lc + 5;
        for (int j = 1; j <= lc + 5; j++) begin
            @(negedge sys_clk);
            if (lc == 0)          exp_s = 1'b0;
            else if (j == 1)      exp_s = d[0];
            else if (j == 2)      exp_s = ~d[0];
            else if (j <= lc + 2) exp_s = d[j-3];
            else                  exp_s = 1'b0;
            chk("stream", int'(stream), int'(exp_s));
            if (j <= last_busy) chk("busy", int'(busy), 1);
        end
    endtask

    initial begin
        bit got;
        int eg [4] = '{1, 2, 1, 2};
        #12;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_stream", int'(stream), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_done_id", int'(done_id), 0);
        chk("rst_hits", int'(hits), 0);
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        det_rst_n = 1'b1;

        rf(0, 16'h0000, 4, 2);
        rf(0, 16'h0006, 4, 1);
        rf(0, 16'hFFFF, 16, 8);
        rf(0, 16'h5555, 16, 0);
        rf(0, 16'h0001, 1, 0);
        rf(1, 16'h0001, 1, 0);

        glog.delete();
        fork
            begin rf(0, 16'h0003, 3, 1); rf(0, 16'h0007, 3, 1); end
            begin rf(1, 16'h0000, 3, 1); rf(1, 16'h0005, 3, 0); end
        join
        chk("gnt_log_len", glog.size(), 4);
        for (int i = 0; i < glog.size() && i < 4; i++) begin
            chk("gnt_seq", glog[i].g, eg[i]);
            if (i > 0) chk("gnt_spacing", glog[i].c - glog[i-1].c, 9);
        end

        rf(0, 16'h00FF, 0, 0);
        rf(0, 16'hFFFF, W + 5, 8);

        // Reset in the middle of SEND with req still held.
        @(posedge sys_clk); #1;
        data0 = 16'h0000; len0 = LW'(8); req[0] = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge sys_clk);
            if (gnt[0]) got = 1'b1;
        end
        chk("mid_gnt_seen", int'(got), 1);
        repeat (5) @(posedge sys_clk);
        #1;
        chk("pre_rst_busy", int'(busy), 1);
        sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_stream", int'(stream), 0);
        chk("mid_rst_gnt", int'(gnt), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_hits", int'(hits), 0);
        repeat (3) begin
            @(negedge sys_clk);
            chk("rst_hold_gnt", int'(gnt), 0);
            chk("rst_hold_done", int'(done), 0);
        end
        req[0] = 1'b0;
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        rf(0, 16'h0000, 4, 2);

        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge sys_clk);
        chk("pending_done", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pair_stream_arbiter.md
# pair_stream_arbiter

Shares one `pair_detector` instance between two frame requesters. It grants frames round-robin and serialises each granted frame onto the detector's `stream` input. Before each frame it inserts a two-bit guard so that the detector's state is equivalent to reset. It then counts the detector's `out` pulses that belong to that frame and returns a per-frame hit count. It sits between the requester logic and `pair_detector`, and runs on the same clock.

## Interface
- `W`, 16, maximum frame length in bits (≥2).
- `LW`, `$clog2(W+1)`, width of length and hit-count fields.

- `sys_clk` in 1: clock.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `req` in 2: per-requester frame request, level, held until its `gnt` bit pulses.
- `data0` in W: requester 0 frame bits, LSB sent first.
- `len0` in LW: requester 0 frame length.
- `data1` in W: requester 1 frame bits.
- `len1` in LW: requester 1 frame length.
- `gnt` out 2: one-hot, one-cycle grant pulse.
- `stream` out 1: registered bit to the detector's `stream` input.
- `det_out` in 1: from the detector's `out` output.
- `busy` out 1: high from the grant cycle through the done cycle.
- `done` out 1: one-cycle frame-complete pulse.
- `done_id` out 1: requester index of the completed frame; valid with `done`.
- `hits` out LW: pair count of the completed frame; valid with `done`, held until the next `done`.

## Operation
- Reset values: `gnt`=0, `stream`=0, `busy`=0, `done`=0, `done_id`=0, `hits`=0, FSM=IDLE, round-robin pointer favours requester 0.
- FSM: IDLE → GUARD0 → GUARD1 → SEND → DRAIN (2 cycles) → DONE → IDLE.
- IDLE, arbitration:
  - If exactly one `req` bit is set, grant it.
  - If both are set, grant the requester not granted last. The pointer updates on each grant.
  - In the grant cycle, pulse `gnt[i]`, latch `data_i` and `len_i` (clamped to W), and clear the hit accumulator.
  - Requester inputs may change after the `gnt` pulse.
- `len`=0: skip GUARD and SEND, go directly to DONE. Result is `hits`=0; no bits are driven.
- Guard bits: GUARD0 drives d[0], GUARD1 drives ~d[0].
  - Whatever the prior detector state, the detector is then in the single-~d[0] state.
  - So d[0] can never pair with the previous frame, and frames are fully independent.
- SEND: drives d[0]..d[len-1], one bit per cycle, LSB first.
- Detector pairs are non-overlapping (a completed pair restarts matching). `hits` reports detector pulses as-is; the arbiter does no recomputation.
- `stream` returns to 0 in every cycle outside GUARD/SEND.

## Timing
- Reference: grant cycle g.
  - Guard bits are on `stream` in cycles g+1 and g+2.
  - Frame bit k is on `stream` in cycle g+3+k.
- Detector latency: bit k sampled at the end of its cycle; a pair ending at bit k raises `det_out` in cycle g+5+k.
- Count window: `det_out` is sampled in cycles g+5 … g+4+len (len cycles), using a registered increment.
  - Guard-related pulses (≤ cycle g+4) are excluded.
  - The bit-0 slot is structurally 0.
- `done`, `done_id` and `hits` appear in cycle g+len+5; `busy` drops after that cycle.
- Next `gnt` is at the earliest in cycle g+len+6. For `len`=0, `done` is in g+1.
- Throughput: one frame per len+6 cycles.
- Simultaneous events:
  - A `req` rising during a frame waits.
  - Both requesting in IDLE resolves by pointer.
  - A requester re-requesting right after its `done` loses to a waiting other requester.
- Reset mid-frame: all outputs return to reset values immediately and the frame is dropped with no `done`. The guard makes the next frame correct regardless of detector state.
- `det_out` is not valid before the first clock edge after reset release. The count window never overlaps that edge.
- `hits` never exceeds len/2; no overflow handling is needed.

## Test plan
- Requester 0, data0=0x0000, len0=4 → `gnt`=01, `stream` shows 0,1,0,0,0,0 in cycles g+1..g+6, then `done` at g+9 with `hits`=2 and `done_id`=0.
- data0=0x0006 (bits 0,1,1,0), len0=4 → `hits`=1. data0=0xFFFF, len0=16 → `hits`=8. data0=0x5555, len0=16 → `hits`=0.
- Isolation: frame A data=0x0001, len=1, then frame B data=0x0001, len=1 → both report `hits`=0; no pair across the frame boundary.
- Both `req` held continuously, len=3 each → `gnt` sequence 01,10,01,10, with grants spaced exactly 9 cycles apart.
- len0=0 → `done` at g+1 with `hits`=0; `stream` stays 0. len0=W+5 → clamped to W, `done` at g+W+5.
- Assert `sys_rst_n` low during SEND → `stream`, `gnt`, `busy`, `done` and `hits` go to 0 at once and no `done` fires. After release, a new frame 0x0000 with len=4 still reports `hits`=2.
